// File: rtl/dev_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
//  dev_pkg
//  Shared register map, control-bit positions and key count.
//  Revision: 1.0
// =====================================================================
package dev_pkg;

  localparam logic [31:0] DEF_DATA_ADDR = 32'hF000_0010;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'hF000_0110;

  localparam int NUM_KEYS  = 4;
  localparam int READY_BIT = 0;
  localparam int OVR_BIT   = 2;
  localparam int IE_BIT    = 8;
  localparam int CTRL_W    = IE_BIT + 1;

  typedef struct packed {
    logic ie;
    logic ovr;
    logic ready;
  } ctrl_t;

  function automatic logic [CTRL_W-1:0] ctrl_word(input ctrl_t c);
    logic [CTRL_W-1:0] w;
    w            = '0;
    w[READY_BIT] = c.ready;
    w[OVR_BIT]   = c.ovr;
    w[IE_BIT]    = c.ie;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
//  key_debounce
//  One pushbutton: 2-flop synchronizer, optional debounce counter
//  (KEY_DEBOUNCE_EN) and the stable flop.
//  Revision: 1.0
// =====================================================================
module key_debounce
  import dev_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic stable,
  output logic update
);

  logic sync1, sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= ~key_n;
      sync2 <= sync1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  // update is high on the edge that completes the mismatch run
  assign update = (sync2 != stable) && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (update) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  // Without the debounce stage the timing parameter has no effect.
  wire unused_debounce_cfg = (DEBOUNCE_CYCLES < 2);

  assign update = (sync2 != stable);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stable <= 1'b0;
    else        stable <= sync2;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/key_controller.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
//  key_controller
//  Memory-mapped 4-key pushbutton controller with KDATA/CTRL registers
//  and interrupt. Optional debounce via macro KEY_DEBOUNCE_EN.
//  Revision: 1.0
// =====================================================================
module key_controller
  import dev_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] DATA_ADDR       = DBITS'(DEF_DATA_ADDR),
  parameter logic [DBITS-1:0] CTRL_ADDR       = DBITS'(DEF_CTRL_ADDR),
  parameter int               DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset,
  inout  wire  [DBITS-1:0]    dbus,
  input  logic [DBITS-1:0]    address,
  input  logic                wrtEn,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic                intr
);

  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] update;
  ctrl_t               ctrl;
  logic [DBITS-1:0]    rdata;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk   (clk),
      .reset (reset),
      .key_n (KEY[i]),
      .stable(stable[i]),
      .update(update[i])
    );
  end

  wire change  = |update;
  wire rd_data = (address == DATA_ADDR) && !wrtEn;
  wire rd_ctrl = (address == CTRL_ADDR) && !wrtEn;
  wire wr_ctrl = (address == CTRL_ADDR) &&  wrtEn;
  wire drive   = reset && (rd_data || rd_ctrl);

  // Only the Overrun and IE positions of write data are consumed.
  wire unused_wdata = ^dbus;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= '0;
    end else begin
      if (change)       ctrl.ready <= 1'b1;
      else if (rd_data) ctrl.ready <= 1'b0;

      // A fresh overrun beats a simultaneous write-0 clear
      if (change && ctrl.ready && !rd_data) ctrl.ovr <= 1'b1;
      else if (wr_ctrl && !dbus[OVR_BIT])   ctrl.ovr <= 1'b0;

      if (wr_ctrl) ctrl.ie <= dbus[IE_BIT];
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_data) rdata[NUM_KEYS-1:0] = stable;
    else         rdata[CTRL_W-1:0]   = ctrl_word(ctrl);
  end

  assign dbus = drive ? rdata : {DBITS{1'bz}};
  assign intr = ctrl.ready & ctrl.ie;

endmodule
`default_nettype wire

// File: tb/tb_key_controller.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for key_controller: window-based reference model
// checked every cycle plus directed literal expectations.
module tb_key_controller;

  localparam int          DB    = 4;
  localparam logic [31:0] DA    = 32'hF000_0010;
  localparam logic [31:0] CA    = 32'hF000_0110;
  localparam logic [31:0] IDLE  = 32'hA5A5_5A5A;
`ifdef KEY_DEBOUNCE_EN
  localparam int          LAT         = DB + 2;
  localparam logic [31:0] GLITCH_CTRL = 32'h0;
`else
  localparam int          LAT         = 3;
  localparam logic [31:0] GLITCH_CTRL = 32'h5;
`endif

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        wrtEn   = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] tb_dout = IDLE;
  logic [3:0]  KEY     = 4'hF;
  wire         intr;
  wire  [31:0] dbus;

  // The bench plays "another bus agent" whenever the DUT must be released.
  wire tb_oe = !reset || wrtEn || (address != DA && address != CA);
  assign dbus = tb_oe ? tb_dout : 32'hzzzz_zzzz;

  key_controller #(
    .DBITS          (32),
    .DATA_ADDR      (DA),
    .CTRL_ADDR      (CA),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .dbus   (dbus),
    .address(address),
    .wrtEn  (wrtEn),
    .KEY    (KEY),
    .intr   (intr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pressed samples delayed two edges; stable follows a key once the
  // last DB delayed samples all disagree with it.
  logic [3:0] m_dly0 = '0, m_dly1 = '0, m_st = '0;
  logic [3:0] m_hist [DB-1];
  logic       m_ready = 1'b0, m_ovr = 1'b0, m_ie = 1'b0;
  logic [3:0] nst, hitv;
  logic       rd_d, wr_c, chg;

  always_comb begin
    hitv = '0;
    nst  = m_st;
`ifdef KEY_DEBOUNCE_EN
    for (int k = 0; k < 4; k++) begin
      hitv[k] = (m_dly1[k] != m_st[k]);
      for (int j = 0; j < DB - 1; j++)
        hitv[k] = hitv[k] && (m_hist[j][k] != m_st[k]);
      if (hitv[k]) nst[k] = m_dly1[k];
    end
`else
    nst = m_dly1;
`endif
    rd_d = (address == DA) && !wrtEn;
    wr_c = (address == CA) && wrtEn;
    chg  = (nst != m_st);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_dly0 <= '0; m_dly1 <= '0; m_st <= '0;
      for (int j = 0; j < DB - 1; j++) m_hist[j] <= '0;
      m_ready <= 1'b0; m_ovr <= 1'b0; m_ie <= 1'b0;
    end else begin
      m_dly0    <= ~KEY;
      m_dly1    <= m_dly0;
      m_hist[0] <= m_dly1;
      for (int j = 1; j < DB - 1; j++) m_hist[j] <= m_hist[j-1];
      m_st    <= nst;
      m_ready <= chg ? 1'b1 : (rd_d ? 1'b0 : m_ready);
      m_ovr   <= (chg && m_ready && !rd_d) ? 1'b1 : ((wr_c && !tb_dout[2]) ? 1'b0 : m_ovr);
      if (wr_c) m_ie <= tb_dout[8];
    end
  end

  function automatic logic [31:0] model_bus();
    if (tb_oe)         return tb_dout;
    if (address == DA) return {28'h0, m_st};
    return (m_ready ? 32'h1 : 32'h0) + (m_ovr ? 32'h4 : 32'h0) + (m_ie ? 32'h100 : 32'h0);
  endfunction

  always @(posedge clk) begin
    #1;
    chk("model_intr", {31'h0, intr}, {31'h0, m_ready & m_ie});
    chk("model_dbus", dbus, model_bus());
  end

  // ---------------- directed stimulus ----------------
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk); address = a; wrtEn = 1'b0;
    @(posedge clk); #1; chk(nm, dbus, exp);
    @(negedge clk); address = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); address = a; wrtEn = 1'b1; tb_dout = d;
    @(negedge clk); address = 32'h0; wrtEn = 1'b0; tb_dout = IDLE;
  endtask

  task automatic setkey(input logic [3:0] k);
    @(negedge clk); KEY = k;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset: bus released even when addressed, then registers read 0
    cyc(3);
    rd(DA, IDLE, "reset_bus_released");
    chk("reset_intr", {31'h0, intr}, 32'h0);
    @(negedge clk); reset = 1'b1;
    rd(DA, 32'h0, "reset_kdata");
    rd(CA, 32'h0, "reset_ctrl");
    chk("reset_intr_after", {31'h0, intr}, 32'h0);

    // Press key 0 and hold; then a 3-cycle glitch
    setkey(4'hE); cyc(10);
    rd(CA, 32'h1, "press_ready");
    rd(DA, 32'h1, "press_kdata");
    setkey(4'hD); cyc(2); setkey(4'hE); cyc(8);
    rd(CA, GLITCH_CTRL, "glitch_ctrl");
    rd(DA, 32'h1, "glitch_kdata");

    // Overrun and its write-0 clear
    setkey(4'hF); cyc(10);
    setkey(4'hE); cyc(10);
    setkey(4'hF); cyc(10);
    rd(CA, 32'h5, "ovr_ctrl");
    wr(CA, 32'h0);
    rd(CA, 32'h1, "ovr_cleared");
    rd(DA, 32'h0, "ovr_kdata");
    rd(CA, 32'h0, "ovr_ready_cleared");

    // Interrupt
    wr(CA, 32'h100);
    setkey(4'h7); cyc(10);
    chk("intr_set", {31'h0, intr}, 32'h1);
    rd(CA, 32'h101, "intr_ctrl");
    rd(DA, 32'h8, "intr_kdata");
    chk("intr_cleared", {31'h0, intr}, 32'h0);

    // Collision: KDATA read on the edge the stable value changes
    setkey(4'hF); cyc(10);
    setkey(4'hB); cyc(LAT - 2);
    rd(DA, 32'h4, "collide_kdata");
    rd(CA, 32'h101, "collide_ctrl");
    wr(DA, 32'h100);
    rd(CA, 32'h101, "wr_data_ignored_ctrl");
    rd(DA, 32'h4, "wr_data_ignored_kdata");

    // Exact latency from KEY edge to KDATA / Ready
    setkey(4'hF); cyc(10);
    rd(DA, 32'h0, "lat_clear");
    @(negedge clk); KEY = 4'h7; address = DA;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk); #1;
      chk("lat_kdata", dbus, (e == LAT) ? 32'h8 : 32'h0);
      chk("lat_intr", {31'h0, intr}, (e == LAT) ? 32'h1 : 32'h0);
    end
    @(negedge clk); address = 32'h0;

    // Key held through reset is reported after release
    @(negedge clk); reset = 1'b0; KEY = 4'hE;
    cyc(3);
    rd(CA, IDLE, "held_reset_released");
    @(negedge clk); reset = 1'b1;
    cyc(10);
    rd(CA, 32'h1, "held_reset_ready");
    rd(DA, 32'h1, "held_reset_kdata");

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
